triangle_fetch: RTL
===================

Name: triangle_fetch

Overview:
Parametrised successor to the single-triangle fetch unit. On `start`, fetches a batch of `num_triangles` triangles over the AXI4-Lite master read channels. For each triangle it reads the packed vertex record and one color word, then presents the triangle on a valid/ready output stream to the raster front end. It adds batch addressing, configurable coordinate width, output backpressure, AXI error detection and a progress counter.

Parameters:
MADDR_WIDTH, 32, AXI address width
COORD_WIDTH, 16, bits per vertex coordinate (1..32)
COLOR_WIDTH, 16, bits per triangle color (1..32)
COUNT_WIDTH, 16, width of triangle count/index
Derived VTX_WORDS = ceil(9*COORD_WIDTH/32); 5 at default.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  batch start pulse
addr_vertex  in  MADDR_WIDTH  byte base address of vertex records
addr_colors  in  MADDR_WIDTH  byte base address of color words
num_triangles  in  COUNT_WIDTH  triangles in batch
tri_valid  out  1  triangle output valid
tri_ready  in  1  consumer accepts triangle
vertexes  out  3x3xCOORD_WIDTH  [vertex][x,y,z] coordinates
colors  out  COLOR_WIDTH  triangle color
tri_index  out  COUNT_WIDTH  index of triangle currently on output / next to fetch
eoc  out  1  batch finished (level)
err  out  1  batch aborted by AXI error (level)
AXI4-Lite master: awaddr_m, awprot_m[2:0], awvalid_m, awready_m, wvalid_m, wready_m, wdata_m[31:0], wstrb_m[3:0], bresp_m[1:0], bvalid_m, bready_m, araddr_m, arprot_m[2:0], arvalid_m, arready_m, rdata_m[31:0], rresp_m[1:0], rvalid_m, rready_m (standard directions).

Behaviour:
- Single clock `clk`; asynchronous active-low reset `reset_n`. Reset mid-batch abandons any outstanding read and returns to IDLE.
- Reset values: all outputs 0. State is IDLE; vertex/color registers, tri_index, eoc and err are 0.
- Write channels are tied 0. arprot_m = 0.
- States and transitions:
  - IDLE → RD_VTX on start.
  - RD_VTX → RD_COL after the last vertex word.
  - RD_COL → OUT after the color word.
  - OUT → RD_VTX on tri_valid&&tri_ready if triangles remain; otherwise OUT → DONE.
  - DONE → RD_VTX on start.
  - Any read state → DONE on error.
- Start handling:
  - start latches addr_vertex, addr_colors and num_triangles; clears tri_index, eoc and err.
  - start with num_triangles == 0 goes to DONE directly. eoc=1 on the next cycle and no AXI traffic is issued.
  - start is ignored in RD_VTX, RD_COL and OUT.
- Addressing:
  - Word w of triangle i: araddr = addr_vertex + (i*VTX_WORDS + w)*4.
  - Color: araddr = addr_colors + i*4.
  - Arithmetic is modulo 2^MADDR_WIDTH; wrap is allowed.
- Read handshake:
  - At most one read outstanding.
  - arvalid_m asserts in a read state when no read is outstanding. araddr_m is held stable until arvalid_m&&arready_m.
  - rready_m = 1 only while a read is outstanding.
  - A new AR may issue the cycle after the R handshake.
- Data capture:
  - Vertex word w is stored at bits [32w+31:32w] of a 32*VTX_WORDS concatenation.
  - vertexes[v][c] = concat[(3v+c)*COORD_WIDTH +: COORD_WIDTH]; unused top bits are ignored.
  - colors = color word[COLOR_WIDTH-1:0].
- Output stream:
  - tri_valid = (state == OUT).
  - vertexes and colors are stable while tri_valid=1 and tri_ready=0; they hold their last value elsewhere.
  - tri_index increments on each accepted triangle.
- Completion:
  - eoc = (state == DONE).
  - After the final accept, DONE is entered the next cycle with tri_index == num_triangles.
- Errors:
  - rresp SLVERR or DECERR on any R handshake sets err. The block goes to DONE without presenting that triangle, and tri_index = index of the failing triangle.
  - OKAY and EXOKAY are both treated as success.

Test Plan:
- Reset, then one triangle at vertex 0x1000 / color 0x2000, zero-wait slave:
  - ARs go to 0x1000, 0x1004, 0x1008, 0x100C, 0x1010, then 0x2000.
  - Data 0x00020001, 0x00040003, … yields vertexes[0][0]=1, [0][1]=2, [2][2]=9.
  - colors = 0xBEEF from color word 0xDEADBEEF; eoc=1, tri_index=1.
- Batch of 3, arready delayed 0–3 cycles at random:
  - Triangle 2 fetches 0x1028..0x1038 and 0x2008.
  - araddr_m is stable while waiting for arready; eoc=1 only after the third accept.
- tri_ready held low for 10 cycles in OUT:
  - tri_valid=1 and outputs are unchanged throughout.
  - No AR is issued until the accept.
- num_triangles=0 → eoc=1 one cycle after start; arvalid_m never asserts.
- SLVERR on the color read of triangle 1 of 4 → err=1, eoc=1, tri_index=1; only triangle 0 is ever presented.
- Other sequences:
  - start pulsed during RD_VTX is ignored.
  - reset_n asserted mid-read → outputs 0, then a fresh batch completes correctly.
  - COORD_WIDTH=32 build → VTX_WORDS=9 and correct unpacking.

Source files
------------

// File: rtl/triangle_fetch.sv
// Batch triangle fetcher: reads packed vertex words plus one color word per triangle
// over AXI4-Lite (one read in flight) and hands each triangle to a valid/ready stream.
//
// state    | meaning
// IDLE     | waiting for the first start after reset
// RD_VTX   | reading the vertex words of triangle tri_index
// RD_COL   | reading the color word of triangle tri_index
// OUT      | triangle presented, waiting for tri_ready
// DONE     | batch finished or aborted (eoc level), waiting for start
module triangle_fetch #(
    parameter int MADDR_WIDTH = 32,
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [MADDR_WIDTH-1:0]               addr_vertex,
    input  logic [MADDR_WIDTH-1:0]               addr_colors,
    input  logic [COUNT_WIDTH-1:0]               num_triangles,
    output logic                                 tri_valid,
    input  logic                                 tri_ready,
    output logic [2:0][2:0][COORD_WIDTH-1:0]     vertexes,
    output logic [COLOR_WIDTH-1:0]               colors,
    output logic [COUNT_WIDTH-1:0]               tri_index,
    output logic                                 eoc,
    output logic                                 err,
    output logic [MADDR_WIDTH-1:0]               awaddr_m,
    output logic [2:0]                           awprot_m,
    output logic                                 awvalid_m,
    input  logic                                 awready_m,
    output logic                                 wvalid_m,
    input  logic                                 wready_m,
    output logic [31:0]                          wdata_m,
    output logic [3:0]                           wstrb_m,
    input  logic [1:0]                           bresp_m,
    input  logic                                 bvalid_m,
    output logic                                 bready_m,
    output logic [MADDR_WIDTH-1:0]               araddr_m,
    output logic [2:0]                           arprot_m,
    output logic                                 arvalid_m,
    input  logic                                 arready_m,
    input  logic [31:0]                          rdata_m,
    input  logic [1:0]                           rresp_m,
    input  logic                                 rvalid_m,
    output logic                                 rready_m
);

    localparam int VTX_WORDS = (9 * COORD_WIDTH + 31) / 32;
    localparam int WORD_W    = $clog2(VTX_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD_VTX, S_RD_COL, S_OUT, S_DONE} state_t;

    state_t                            state_q, state_d;
    logic                              rd_out_q, rd_out_d;
    logic [WORD_W-1:0]                 word_q, word_d;
    logic [MADDR_WIDTH-1:0]            base_vtx_q, base_vtx_d;
    logic [MADDR_WIDTH-1:0]            base_col_q, base_col_d;
    logic [COUNT_WIDTH-1:0]            num_q, num_d;
    logic [COUNT_WIDTH-1:0]            idx_q, idx_d;
    logic                              err_q, err_d;
    logic [VTX_WORDS-1:0][31:0]        vtx_buf_q, vtx_buf_d;
    logic [2:0][2:0][COORD_WIDTH-1:0]  vert_q, vert_d;
    logic [COLOR_WIDTH-1:0]            color_q, color_d;

    logic                              in_read, ar_hs, r_hs, r_fail, last_word;
    logic [COUNT_WIDTH-1:0]            idx_inc;
    logic [32*VTX_WORDS-1:0]           vtx_flat;
    logic [MADDR_WIDTH-1:0]            vtx_off;
    logic                              unused_sig;

    assign vtx_flat   = vtx_buf_q;
    assign unused_sig = ^{awready_m, wready_m, bresp_m, bvalid_m, rresp_m[0], vtx_buf_q};

    always_comb begin
        in_read   = (state_q == S_RD_VTX) || (state_q == S_RD_COL);
        ar_hs     = in_read && !rd_out_q && arready_m;
        r_hs      = rd_out_q && rvalid_m;
        r_fail    = r_hs && rresp_m[1];
        last_word = (word_q == WORD_W'(VTX_WORDS - 1));
        idx_inc   = idx_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rd_out_q   <= 1'b0;
            word_q     <= '0;
            base_vtx_q <= '0;
            base_col_q <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            vtx_buf_q  <= '0;
            vert_q     <= '0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_out_q   <= rd_out_d;
            word_q     <= word_d;
            base_vtx_q <= base_vtx_d;
            base_col_q <= base_col_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            vtx_buf_q  <= vtx_buf_d;
            vert_q     <= vert_d;
            color_q    <= color_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_out_d   = rd_out_q;
        word_d     = word_q;
        base_vtx_d = base_vtx_q;
        base_col_d = base_col_q;
        num_d      = num_q;
        idx_d      = idx_q;
        err_d      = err_q;
        vtx_buf_d  = vtx_buf_q;
        vert_d     = vert_q;
        color_d    = color_q;
        if (ar_hs) rd_out_d = 1'b1;
        if (r_hs)  rd_out_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_vtx_d = addr_vertex;
                    base_col_d = addr_colors;
                    num_d      = num_triangles;
                    idx_d      = '0;
                    err_d      = 1'b0;
                    word_d     = '0;
                    state_d    = (num_triangles == '0) ? S_DONE : S_RD_VTX;
                end
            end
            S_RD_VTX: begin
                if (r_fail) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (r_hs) begin
                    vtx_buf_d[word_q] = rdata_m;
                    if (last_word) begin
                        word_d  = '0;
                        state_d = S_RD_COL;
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
            S_RD_COL: begin
                if (r_fail) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (r_hs) begin
                    // Output registers change only here, so they hold through the next fetch.
                    color_d = rdata_m[COLOR_WIDTH-1:0];
                    for (int v = 0; v < 3; v++) begin
                        for (int c = 0; c < 3; c++) begin
                            vert_d[v][c] = vtx_flat[(3*v+c)*COORD_WIDTH +: COORD_WIDTH];
                        end
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (tri_ready) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == num_q) ? S_DONE : S_RD_VTX;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tri_valid = (state_q == S_OUT);
        eoc       = (state_q == S_DONE);
        err       = err_q;
        tri_index = idx_q;
        vertexes  = vert_q;
        colors    = color_q;
        arvalid_m = in_read && !rd_out_q;
        rready_m  = rd_out_q;
        arprot_m  = 3'b000;
        vtx_off   = (MADDR_WIDTH'(idx_q) * MADDR_WIDTH'(VTX_WORDS) + MADDR_WIDTH'(word_q)) << 2;
        if (state_q == S_RD_COL)      araddr_m = base_col_q + (MADDR_WIDTH'(idx_q) << 2);
        else if (state_q == S_RD_VTX) araddr_m = base_vtx_q + vtx_off;
        else                          araddr_m = '0;
        awaddr_m  = '0;
        awprot_m  = 3'b000;
        awvalid_m = 1'b0;
        wvalid_m  = 1'b0;
        wdata_m   = '0;
        wstrb_m   = 4'b0000;
        bready_m  = 1'b0;
    end

endmodule
